// File: rtl/tnn_pkg.sv
// Shared types and helpers for the temporal-coded neuron fabric.
// Holds the arbiter state encoding and pulse-length arithmetic.
package tnn_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } arb_state_t;

    localparam int unsigned DefaultWres = 3;

    function automatic int unsigned pulse_len(input int unsigned wres);
        return 32'd1 << wres;
    endfunction

endpackage

// File: rtl/spike_rr_pick.sv
// Round-robin picker: first set bit of cand at or above ptr, wrapping modulo NREQ.
// Purely combinational rotate, priority-encode, rotate back.
module spike_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] cand,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  grant_idx,
    output logic [NREQ-1:0] grant_onehot
);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    int unsigned     sum;

    always_comb begin
        rot = NREQ'({cand, cand} >> ptr);
        any = |cand;
        off = '0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDW'(k);
            end
        end
        sum = 32'(ptr) + 32'(off);
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        grant_idx    = IDW'(sum);
        grant_onehot = '0;
        if (any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spike_pulse_arbiter.sv
// Queues single-cycle spike requests from NREQ channels and serves them round-robin
// as back-to-back 2^WRES-cycle pulses tagged with the owning channel ID.
module spike_pulse_arbiter
    import tnn_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WRES = DefaultWres,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            gamma_clr,
    output logic            pulse_out,
    output logic            pulse_start,
    output logic [IDW-1:0]  pulse_id,
    output logic [NREQ-1:0] pending,
    output logic            busy,
    output logic            drop
);

    localparam logic [WRES-1:0] CntMax = WRES'(pulse_len(WRES) - 1);

    arb_state_t      state_q, state_d;
    logic [WRES-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            drop_q, drop_d;
    logic            pulse_out_q, pulse_out_d;
    logic            pulse_start_q, pulse_start_d;
    logic [IDW-1:0]  pulse_id_q, pulse_id_d;

    logic [NREQ-1:0] cand;
    logic            any;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_onehot;
    logic [NREQ-1:0] active_oh;
    logic            do_grant;

    assign cand = pending_q | req;

    spike_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .cand         (cand),
        .ptr          (ptr_q),
        .any          (any),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        pulse_out_d   = pulse_out_q;
        pulse_start_d = 1'b0;
        pulse_id_d    = pulse_id_q;
        do_grant      = 1'b0;
        active_oh     = '0;
        if (state_q == ACTIVE) begin
            active_oh[pulse_id_q] = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                do_grant = any;
            end
            ACTIVE: begin
                if (cnt_q == CntMax) begin
                    if (any) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        pulse_out_d = 1'b0;
                        pulse_id_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            state_d       = ACTIVE;
            cnt_d         = '0;
            pulse_out_d   = 1'b1;
            pulse_start_d = 1'b1;
            pulse_id_d    = grant_idx;
            ptr_d         = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        // A repeat request merges into the existing entry but is flagged.
        pending_d = cand & ~(do_grant ? grant_onehot : '0);
        drop_d    = drop_q | (|(req & (pending_q | active_oh)));

        if (gamma_clr) begin
            state_d       = IDLE;
            cnt_d         = '0;
            ptr_d         = ptr_q;
            pending_d     = '0;
            drop_d        = 1'b0;
            pulse_out_d   = 1'b0;
            pulse_start_d = 1'b0;
            pulse_id_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            pending_q     <= '0;
            drop_q        <= 1'b0;
            pulse_out_q   <= 1'b0;
            pulse_start_q <= 1'b0;
            pulse_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            drop_q        <= drop_d;
            pulse_out_q   <= pulse_out_d;
            pulse_start_q <= pulse_start_d;
            pulse_id_q    <= pulse_id_d;
        end
    end

    assign pulse_out   = pulse_out_q;
    assign pulse_start = pulse_start_q;
    assign pulse_id    = pulse_id_q;
    assign pending     = pending_q;
    assign busy        = pulse_out_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_spike_pulse_arbiter.sv
// Bench for spike_pulse_arbiter: directed scenarios plus random traffic, with a
// behavioural owner/remaining-cycles model feeding an expected-output queue.
module tb_spike_pulse_arbiter;

    localparam int NREQ = 4;
    localparam int WRES = 3;
    localparam int IDW  = $clog2(NREQ);
    localparam int PLEN = 1 << WRES;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            gamma_clr = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            pulse_out, pulse_start, busy, drop;
    logic [IDW-1:0]  pulse_id;
    logic [NREQ-1:0] pending;

    spike_pulse_arbiter #(
        .NREQ (NREQ),
        .WRES (WRES),
        .IDW  (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gamma_clr   (gamma_clr),
        .pulse_out   (pulse_out),
        .pulse_start (pulse_start),
        .pulse_id    (pulse_id),
        .pending     (pending),
        .busy        (busy),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            po;
        logic            ps;
        logic [IDW-1:0]  id;
        logic [NREQ-1:0] pend;
        logic            drp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: owner channel (-1 when idle) and how many pulse cycles it has left.
    int              m_owner  = -1;
    int              m_remain = 0;
    int              m_ptr    = 0;
    logic [NREQ-1:0] m_pend   = '0;
    logic            m_drop   = 1'b0;
    logic            m_start  = 1'b0;

    always @(posedge clk) begin : model
        logic [NREQ-1:0] cand;
        exp_t            e;
        int              g;
        m_start = 1'b0;
        if (rst) begin
            m_owner = -1; m_remain = 0; m_ptr = 0; m_pend = '0; m_drop = 1'b0;
        end else if (gamma_clr) begin
            m_owner = -1; m_remain = 0; m_pend = '0; m_drop = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (m_pend[i] || m_owner == i)) m_drop = 1'b1;
            end
            cand = m_pend | req;
            if (m_owner < 0 || m_remain == 1) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && cand[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
                if (g >= 0) begin
                    m_owner  = g;
                    m_remain = PLEN;
                    m_start  = 1'b1;
                    m_ptr    = (g + 1) % NREQ;
                    cand[g]  = 1'b0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_remain = m_remain - 1;
            end
            m_pend = cand;
        end
        e.po   = (m_owner >= 0);
        e.ps   = m_start;
        e.id   = (m_owner >= 0) ? IDW'(m_owner) : '0;
        e.pend = m_pend;
        e.drp  = m_drop;
        exp_q.push_back(e);
    end

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pulse_out", int'(pulse_out), int'(e.po));
            check("pulse_start", int'(pulse_start), int'(e.ps));
            check("pulse_id", int'(pulse_id), int'(e.id));
            check("pending", int'(pending), int'(e.pend));
            check("busy", int'(busy), int'(e.po));
            check("drop", int'(drop), int'(e.drp));
        end
    end

    task automatic cyc(input logic [NREQ-1:0] r, input logic g, input logic rs);
        @(negedge clk);
        req       = r;
        gamma_clr = g;
        rst       = rs;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        idle(3);
        // Single request on channel 2.
        cyc(4'b0100, 1'b0, 1'b0); idle(12);
        // Two simultaneous requests served back-to-back.
        cyc(4'b1001, 1'b0, 1'b0); idle(20);
        // Fairness: all four pending while ch0 active, so order is 1,2,3,0.
        cyc(4'b0001, 1'b0, 1'b0); idle(2);
        cyc(4'b1111, 1'b0, 1'b0); idle(40);
        // Repeated requests on the active channel set drop and queue one more pulse.
        cyc(4'b0010, 1'b0, 1'b0); idle(1);
        cyc(4'b0010, 1'b0, 1'b0); idle(1);
        cyc(4'b0010, 1'b0, 1'b0); idle(20);
        // gamma_clr aborts the pulse, flushes pending and discards same-cycle req.
        cyc(4'b0001, 1'b0, 1'b0); cyc(4'b0100, 1'b0, 1'b0); idle(1);
        cyc(4'b1000, 1'b1, 1'b0); idle(12);
        // Reset mid-pulse, then a fresh request.
        cyc(4'b0001, 1'b0, 1'b0); idle(4);
        cyc('0, 1'b0, 1'b1); idle(1);
        cyc(4'b0010, 1'b0, 1'b0); idle(12);
        // Random traffic with occasional flushes and resets.
        for (int t = 0; t < 3000; t++) begin
            logic [NREQ-1:0] r;
            for (int i = 0; i < NREQ; i++) r[i] = ($urandom_range(0, 5) == 0);
            cyc(r, ($urandom_range(0, 79) == 0), ($urandom_range(0, 399) == 0));
        end
        idle(2);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_pulse_arbiter.md
Name: spike_pulse_arbiter

Overview:
- Shares one pulse-stretching resource among NREQ neuron channels.
- Each channel raises single-cycle spike requests, as produced by pac.
- The block queues requests, grants them round-robin, and drives a (2^WRES)-cycle-wide output pulse tagged with the owning channel ID.
- Sits between the pac outputs of a column and the downstream temporal-coded fabric. gamma_clr bounds each gamma cycle.

Parameters:
NREQ, 4, number of requesting channels (>=2)
WRES, 3, weight resolution; pulse width = wmax+1 = 2^WRES cycles
IDW, $clog2(NREQ), width of channel ID

Ports:
clk  input  1  unit clock for temporal encoding
rst  input  1  reset, synchronous, active-high
req  input  NREQ  per-channel 1-cycle spike request
gamma_clr  input  1  gamma-cycle boundary: flush pending requests and abort the active pulse
pulse_out  output  1  stretched pulse, high 2^WRES cycles per grant
pulse_start  output  1  high on first cycle of each granted pulse
pulse_id  output  IDW  channel owning current pulse; valid while pulse_out=1, else 0
pending  output  NREQ  queued, not-yet-granted requests
busy  output  1  equals pulse_out
drop  output  1  sticky: a request hit an already-pending or currently-active channel

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cnt=0, pending=0, ptr=0, drop=0. All outputs 0.
- All outputs are registered. Latency is 1 cycle: if req[i] is sampled at edge t while IDLE, pulse_out is high for cycles t+1 .. t+2^WRES.
- Request capture:
  - Each edge: pending <= (pending | req) & ~grant_onehot.
  - If req[i] arrives while pending[i]=1 or channel i is active, set drop=1. The request merges and is not queued twice.
- Arbitration (combinational sub-module):
  - cand = pending | req.
  - Pick the first set bit scanning from ptr upward, with modulo-NREQ wrap.
  - On each grant of channel g: ptr <= (g+1) mod NREQ.
- FSM, states IDLE and ACTIVE:
  - IDLE: if cand != 0, grant the pick. Go to ACTIVE with cnt=0, pulse_start=1, pulse_id=g.
  - ACTIVE: cnt increments each cycle. At cnt = 2^WRES-1 (the last pulse cycle):
    - If cand != 0, grant the next channel at the same edge. Pulses are back-to-back with no gap: pulse_out stays 1, pulse_start pulses, pulse_id changes.
    - Otherwise go to IDLE.
  - cnt is WRES bits wide and wraps naturally to 0 at the handoff.
- Requests arriving during ACTIVE are only queued. There is no preemption.
- gamma_clr (priority over everything except rst):
  - At that edge: pending=0, drop=0, state=IDLE, cnt=0. pulse_out drops the next cycle.
  - req asserted in the same cycle as gamma_clr is discarded.
  - ptr is preserved.
- rst mid-pulse: pulse_out is 0 on the cycle after the edge; all state is cleared.
- Single channel, NREQ consecutive 1-cycle requests on the same channel during its active pulse: each sets drop. One pending entry remains, and it is served next.

Decomposition:
- Shared package tnn_pkg:
  - arb_state_t enum {IDLE, ACTIVE}.
  - Default WRES constant.
  - Function pulse_len(WRES) = 2^WRES.
- Sub-module spike_rr_pick (NREQ):
  - Inputs: cand, ptr.
  - Outputs: any, grant_idx, grant_onehot.
  - Purely combinational rotate/priority-encode/rotate-back.
- Top contains the FSM, counter, pending/ptr/drop registers and output registers.

Test Plan:
- NREQ=4, WRES=3. req=4'b0100 at cycle 5 -> pulse_out=1 cycles 6..13, pulse_start=1 cycle 6 only, pulse_id=2, then IDLE at 14, ptr=3.
- From reset, req=4'b1001 at cycle 2 -> ch0 pulse cycles 3..10, ch3 pulse cycles 11..18 (pulse_start at 3 and 11, pulse_out continuous), pending=4'b1000 during 3..10, final ptr=0.
- Fairness: ptr=1, pending ch0,1,2,3 all set -> grant order 1,2,3,0; each pulse exactly 8 cycles, total 32 contiguous high cycles.
- Drop: req[1] at cycle 2, again at cycles 4 and 6 -> drop=1 from cycle 5. One pulse cycles 3..10, then a second ch1 pulse cycles 11..18, then IDLE.
- gamma_clr at cycle 6 during a ch0 pulse (started cycle 3), with req[2] pending and req[3] asserted in cycle 6 -> pulse_out=0 from cycle 7, pending=0, drop=0, no further pulses.
- rst at cycle 8 mid-pulse -> all outputs 0 from cycle 9, ptr=0. A new req[1] at cycle 10 -> pulse cycles 11..18.
